taillight_lamp_driver: RTL and testbench

- Output stage directly downstream of the taillight FSM.
- Consumes the FSM's 5-bit logical light command and drives the physical lamp outputs.
- Each lamp channel is PWM-driven, which gives dimmed running (tail) lights, full-brightness brake lights, and incandescent-style fade on turn and brake lamps.
- Also produces a centre brake lamp and a busy flag while any channel is still ramping.

---
 rtl/taillight_lamp_driver.sv | 161 ++++++++++++++++
 tb/tb_taillight_lamp_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/taillight_lamp_driver.sv
// rtl/taillight_lamp_driver.sv - PWM lamp output stage with optional fade (macro TAIL_FADE_EN)
module taillight_lamp_driver #(
    parameter int PWM_BITS  = 8,
    parameter int PWM_DIV   = 390,
    parameter int RAMP_DIV  = 100000,
    parameter int RAMP_STEP = 8,
    parameter int DIM_DUTY  = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] cmd,
    input  logic       tail_on,
    output logic [5:0] lamp,
    output logic       busy
);

    localparam logic [PWM_BITS-1:0] FULL         = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DIM          = PWM_BITS'(DIM_DUTY);
    localparam int                  PDW          = $clog2(PWM_DIV + 1);
    localparam logic [PDW-1:0]      PWM_DIV_LAST = PDW'(PWM_DIV - 1);

    // Channel order matches lamp[3:0]: 0 turn_R, 1 turn_L, 2 brake_R, 3 brake_L
    logic [4:0]          r_cmd;
    logic                r_tail;
    logic [PWM_BITS-1:0] w_target [4];
    logic [PWM_BITS-1:0] r_duty   [4];
    logic [PWM_BITS-1:0] r_shadow [4];
    logic [PDW-1:0]      r_pwm_div;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_pwm_adv;
    logic                w_pwm_wrap;
    logic [3:0]          w_on;
    logic [5:0]          r_lamp;
    logic                r_busy;
    logic                w_busy_nxt;

    // Register the already-clean FSM command and tail enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd  <= '0;
            r_tail <= 1'b0;
        end else begin
            r_cmd  <= cmd;
            r_tail <= tail_on;
        end
    end

    // Per-channel duty targets; brakes fall back to the dim running level
    always_comb begin
        w_target[0] = r_cmd[0] ? FULL : '0;
        w_target[1] = r_cmd[1] ? FULL : '0;
        w_target[2] = r_cmd[2] ? FULL : (r_tail ? DIM : '0);
        w_target[3] = r_cmd[3] ? FULL : (r_tail ? DIM : '0);
    end

`ifdef TAIL_FADE_EN
    localparam int                  RDW       = $clog2(RAMP_DIV + 1);
    localparam logic [RDW-1:0]      RAMP_LAST = RDW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP      = (PWM_BITS + 1)'(RAMP_STEP);

    logic [RDW-1:0]      r_ramp_pre;
    logic                w_tick;
    logic [PWM_BITS:0]   w_up   [4];
    logic [PWM_BITS-1:0] w_next [4];
    logic [3:0]          w_diff;

    assign w_tick = (r_ramp_pre == RAMP_LAST);

    // Free-running ramp prescaler; tick fires on the wrap cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp_pre <= '0;
        end else begin
            r_ramp_pre <= w_tick ? '0 : r_ramp_pre + 1'b1;
        end
    end

    // Next duty one step toward target, clamped so it never passes the target
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_up[i]   = {1'b0, r_duty[i]} + STEP;
            w_next[i] = r_duty[i];
            w_diff[i] = (r_duty[i] != w_target[i]);
            if (r_duty[i] < w_target[i]) begin
                w_next[i] = (w_up[i] > {1'b0, w_target[i]}) ? w_target[i] : w_up[i][PWM_BITS-1:0];
            end else if (r_duty[i] > w_target[i]) begin
                w_next[i] = ({1'b0, r_duty[i]} < ({1'b0, w_target[i]} + STEP)) ?
                            w_target[i] : (r_duty[i] - STEP[PWM_BITS-1:0]);
            end
        end
        w_busy_nxt = |w_diff;
    end

    // Duty moves only on ramp ticks, from wherever it currently is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_duty[i] <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < 4; i++) r_duty[i] <= w_next[i];
        end
    end
`else
    assign w_busy_nxt = 1'b0;

    // Without fade, duty follows the target one cycle after the input register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_duty[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) r_duty[i] <= w_target[i];
        end
    end
`endif

    assign w_pwm_adv  = (r_pwm_div == PWM_DIV_LAST);
    assign w_pwm_wrap = w_pwm_adv && (r_pwm_cnt == FULL);

    // PWM prescaler and counter; the counter wraps naturally from FULL to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_div <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_div <= w_pwm_adv ? '0 : r_pwm_div + 1'b1;
            if (w_pwm_adv) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    // Shadow duty reloads only at the period boundary (pre-tick duty value)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
        end else if (w_pwm_wrap) begin
            for (int i = 0; i < 4; i++) r_shadow[i] <= r_duty[i];
        end
    end

    // PWM compare; full scale is held solidly on
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_on[i] = (r_shadow[i] == FULL) || (r_pwm_cnt < r_shadow[i]);
        end
    end

    // Registered lamp drive and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lamp <= '0;
            r_busy <= 1'b0;
        end else begin
            r_lamp <= {w_on[3] | w_on[2], r_cmd[4], w_on};
            r_busy <= w_busy_nxt;
        end
    end

    assign lamp = r_lamp;
    assign busy = r_busy;

endmodule

// File: tb/tb_taillight_lamp_driver.sv
// tb/tb_taillight_lamp_driver.sv - directed self-checking bench for taillight_lamp_driver
module tb_taillight_lamp_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] cmd = 5'd0;
    logic       tail_on = 1'b0;
    logic [5:0] lamp;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int seen [$];
    int gaps [$];
    int hcnt [6];
    int phase_err;
    int busy_cnt;
    int bad;
    int busy_low;

    taillight_lamp_driver #(
        .PWM_BITS (8),
        .PWM_DIV  (1),
        .RAMP_DIV (4),
        .RAMP_STEP(8),
        .DIM_DUTY (48)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd),
        .tail_on(tail_on),
        .lamp   (lamp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int duty(input int ch);
        case (ch)
            0:       return int'(dut.r_duty[0]);
            1:       return int'(dut.r_duty[1]);
            2:       return int'(dut.r_duty[2]);
            default: return int'(dut.r_duty[3]);
        endcase
    endfunction

    // Record successive duty values of one channel and the clk gaps between them
    task automatic watch(input int ch, input int nchg, input int budget);
        int prev;
        int last_t;
        prev   = duty(ch);
        last_t = 0;
        busy_low = 0;
        seen.delete();
        gaps.delete();
        for (int t = 1; t <= budget && seen.size() < nchg; t++) begin
            @(negedge clk);
            if (t >= 2 && !busy) busy_low++;
            if (duty(ch) != prev) begin
                prev = duty(ch);
                seen.push_back(prev);
                gaps.push_back(t - last_t);
                last_t = t;
            end
        end
    endtask

    task automatic measure(input int n);
        for (int b = 0; b < 6; b++) hcnt[b] = 0;
        phase_err = 0;
        busy_cnt  = 0;
        repeat (n) begin
            @(negedge clk);
            for (int b = 0; b < 6; b++) if (lamp[b]) hcnt[b]++;
            if (lamp[3] !== lamp[2] || lamp[5] !== (lamp[3] | lamp[2])) phase_err++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        wait_clks(3);
        check("reset_lamp", lamp, 0);
        check("reset_busy", busy, 0);

        // Test 1: reset asserted mid-ramp
        cmd = 5'b00011;
        tail_on = 1'b1;
        rst_n = 1'b1;
        wait_clks(20);
`ifdef TAIL_FADE_EN
        check("t1_busy_ramping", busy, 1);
`endif
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_lamp", lamp, 0);
        check("t1_async_busy", busy, 0);
        check("t1_async_duty0", duty(0), 0);
        check("t1_async_duty3", duty(3), 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef TAIL_FADE_EN
        watch(0, 1, 20);
        check("t1_restart_first", (seen.size() > 0) ? seen[0] : -1, 8);
`else
        watch(0, 1, 5);
        check("t1_restart_first", (seen.size() > 0) ? seen[0] : -1, 255);
        check("t1_restart_gap", (gaps.size() > 0) ? gaps[0] : -1, 2);
`endif

        // Test 2: dim running lights
        cmd = 5'b00000;
        wait_clks(700);
        measure(256);
        check("t2_brakeL_high", hcnt[3], 48);
        check("t2_brakeR_high", hcnt[2], 48);
        check("t2_brakeC_high", hcnt[5], 48);
        check("t2_phase", phase_err, 0);
        check("t2_turn_high", hcnt[0] + hcnt[1], 0);
        check("t2_busy", busy_cnt, 0);

        // Test 3 / 6: brakes applied from dim
        cmd = 5'b01100;
`ifdef TAIL_FADE_EN
        watch(3, 26, 200);
        check("t3_steps", seen.size(), 26);
        bad = 0;
        for (int i = 0; i < seen.size(); i++) begin
            if (seen[i] != ((56 + 8 * i > 255) ? 255 : 56 + 8 * i)) bad++;
        end
        check("t3_values", bad, 0);
        bad = 0;
        for (int i = 1; i < gaps.size(); i++) if (gaps[i] != 4) bad++;
        check("t3_tick_gap", bad, 0);
        check("t3_busy_during", busy_low, 0);
        check("t3_brakeR_duty", duty(2), 255);
        @(negedge clk);
        check("t3_busy_after", busy, 0);
`else
        @(negedge clk);
        check("t6_duty_not_yet", duty(3), 48);
        @(negedge clk);
        check("t6_duty_jump_L", duty(3), 255);
        check("t6_duty_jump_R", duty(2), 255);
`endif
        wait_clks(300);
        measure(256);
        check("t3_brakeL_solid", hcnt[3], 256);
        check("t3_brakeR_solid", hcnt[2], 256);
        check("t3_brakeC_solid", hcnt[5], 256);
        check("t3_busy_settled", busy_cnt, 0);

        // Test 4: turn ramp up, then reversed mid-ramp
        cmd = 5'b01110;
`ifdef TAIL_FADE_EN
        watch(1, 10, 100);
        check("t4_up_steps", seen.size(), 10);
        check("t4_up_peak", (seen.size() > 0) ? seen[seen.size()-1] : -1, 80);
        cmd = 5'b01100;
        watch(1, 10, 100);
        check("t4_dn_steps", seen.size(), 10);
        bad = 0;
        for (int i = 0; i < seen.size(); i++) if (seen[i] != 72 - 8 * i) bad++;
        check("t4_dn_values", bad, 0);
        bad = 0;
        for (int i = 0; i < gaps.size(); i++) if (gaps[i] != 4) bad++;
        check("t4_dn_gap", bad, 0);
        check("t4_busy_last_step", busy, 1);
        @(negedge clk);
        check("t4_busy_fall", busy, 0);
        wait_clks(10);
        check("t4_duty_rest", duty(1), 0);
`else
        wait_clks(2);
        check("t4_duty_on", duty(1), 255);
        cmd = 5'b01100;
        @(negedge clk);
        check("t4_duty_hold", duty(1), 255);
        @(negedge clk);
        check("t4_duty_off", duty(1), 0);
        check("t4_busy", busy, 0);
`endif

        // Test 5: reverse lamp is direct, unmodulated
        cmd = 5'b11100;
        @(negedge clk);
        check("t5_rev_lat1", lamp[4], 0);
        @(negedge clk);
        check("t5_rev_on", lamp[4], 1);
        measure(256);
        check("t5_rev_solid", hcnt[4], 256);
        cmd = 5'b01100;
        @(negedge clk);
        check("t5_rev_hold", lamp[4], 1);
        @(negedge clk);
        check("t5_rev_off", lamp[4], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
